multicycle_controller: RTL and testbench

- Parametrised multi-cycle control unit for the CPU datapath.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and latches the opcode once per instruction.
- Drives per-state enables with a memory request/ready handshake and an external stall.
- Sits between the instruction register/memory interface and the datapath (ALU, register file, PC).

---
 rtl/ctrl_pkg.sv | 46 ++++
 rtl/multicycle_controller_if.sv | 40 ++++
 rtl/ctrl_alu_decode.sv | 26 ++
 rtl/multicycle_controller.sv | 167 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-cycle control unit.
//   - ctrl_state_e : controller state encoding (also exported on ctrl_state)
//   - OP_*         : instruction opcodes (4-bit base encoding)
//   - ALU_*        : ALU function select encodings
//   - PC_SRC_*     : PC source mux select encodings
package ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } ctrl_state_e;

  localparam logic [3:0] OP_LI    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_OR    = 4'b0101;
  localparam logic [3:0] OP_SLT   = 4'b0110;
  localparam logic [3:0] OP_MOV   = 4'b0111;
  localparam logic [3:0] OP_LOAD  = 4'b1000;
  localparam logic [3:0] OP_STORE = 4'b1001;
  localparam logic [3:0] OP_BEQ   = 4'b1010;
  localparam logic [3:0] OP_AND   = 4'b1011;
  localparam logic [3:0] OP_XOR   = 4'b1100;
  localparam logic [3:0] OP_NOR   = 4'b1101;
  localparam logic [3:0] OP_JMP   = 4'b1110;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [2:0] ALU_AND  = 3'd0;
  localparam logic [2:0] ALU_PASS = 3'd1;
  localparam logic [2:0] ALU_ADD  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_SLT  = 3'd5;
  localparam logic [2:0] ALU_SUB  = 3'd6;
  localparam logic [2:0] ALU_NOR  = 3'd7;

  localparam logic [1:0] PC_SRC_INC    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: controller <-> datapath/memory signal bundle.
//   master (controller): inputs op_code, zero, mem_ready, stall;
//                        outputs mem_req, mem_we, ir_write, pc_write, pc_src, reg_write,
//                        wb_sel, alu_op, ctrl_state, halted, retired, perf_cycles, perf_instrs
//   slave  (environment): the mirror image.
interface multicycle_controller_if #(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned ALUOP_W  = 3,
  parameter int unsigned CNT_W    = 32
) ();
  logic [OPCODE_W-1:0] op_code;
  logic                zero;
  logic                mem_ready;
  logic                stall;
  logic                mem_req;
  logic                mem_we;
  logic                ir_write;
  logic                pc_write;
  logic [1:0]          pc_src;
  logic                reg_write;
  logic                wb_sel;
  logic [ALUOP_W-1:0]  alu_op;
  logic [2:0]          ctrl_state;
  logic                halted;
  logic                retired;
  logic [CNT_W-1:0]    perf_cycles;
  logic [CNT_W-1:0]    perf_instrs;

  modport master (
    input  op_code, zero, mem_ready, stall,
    output mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, wb_sel, alu_op,
           ctrl_state, halted, retired, perf_cycles, perf_instrs
  );

  modport slave (
    output op_code, zero, mem_ready, stall,
    input  mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, wb_sel, alu_op,
           ctrl_state, halted, retired, perf_cycles, perf_instrs
  );
endinterface

// File: rtl/ctrl_alu_decode.sv
// ctrl_alu_decode: pure combinational opcode -> ALU function map.
//   i_op_code : latched opcode
//   o_alu_op  : ALU function select (pass-through for unlisted opcodes)
module ctrl_alu_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned ALUOP_W  = 3
) (
  input  logic [OPCODE_W-1:0] i_op_code,
  output logic [ALUOP_W-1:0]  o_alu_op
);
  always_comb begin
    o_alu_op = ALUOP_W'(ALU_PASS);
    case (i_op_code)
      OPCODE_W'(OP_ADD): o_alu_op = ALUOP_W'(ALU_ADD);
      OPCODE_W'(OP_SUB): o_alu_op = ALUOP_W'(ALU_SUB);
      OPCODE_W'(OP_OR):  o_alu_op = ALUOP_W'(ALU_OR);
      OPCODE_W'(OP_SLT): o_alu_op = ALUOP_W'(ALU_SLT);
      OPCODE_W'(OP_AND): o_alu_op = ALUOP_W'(ALU_AND);
      OPCODE_W'(OP_XOR): o_alu_op = ALUOP_W'(ALU_XOR);
      OPCODE_W'(OP_NOR): o_alu_op = ALUOP_W'(ALU_NOR);
      default:           o_alu_op = ALUOP_W'(ALU_PASS);
    endcase
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB sequencer for a multi-cycle datapath.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : multicycle_controller_if.master (opcode/flags/handshake in, enables out)
// Optional: define CTRL_PERF_CNT_EN to build the cycle / retired-instruction counters;
// otherwise perf_cycles and perf_instrs are tied to 0.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned ALUOP_W  = 3,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  multicycle_controller_if.master  bus
);
  ctrl_state_e         r_state, w_state_nxt;
  logic [OPCODE_W-1:0] r_op_reg, w_op_reg_nxt;
  logic [ALUOP_W-1:0]  w_alu_op;
  logic                w_adv, w_retired, w_op_illegal;
  logic                w_is_load, w_is_store;

  // Opcodes wider than the 4-bit base encoding are illegal.
  if (OPCODE_W > 4) begin : g_wide_op
    assign w_op_illegal = |bus.op_code[OPCODE_W-1:4];
  end else begin : g_base_op
    assign w_op_illegal = 1'b0;
  end

  assign w_is_load  = (r_op_reg == OPCODE_W'(OP_LOAD));
  assign w_is_store = (r_op_reg == OPCODE_W'(OP_STORE));

  ctrl_alu_decode #(
    .OPCODE_W (OPCODE_W),
    .ALUOP_W  (ALUOP_W)
  ) u_alu_decode (
    .i_op_code (r_op_reg),
    .o_alu_op  (w_alu_op)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_op_reg <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_op_reg <= w_op_reg_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_op_reg_nxt   = r_op_reg;
    w_retired      = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = PC_SRC_INC;
    bus.reg_write  = 1'b0;
    bus.wb_sel     = 1'b0;
    bus.alu_op     = '0;
    bus.halted     = 1'b0;
    // A memory state only advances once the access completes; stall holds everything.
    w_adv = !bus.stall && ((r_state == StFetch || r_state == StMem) ? bus.mem_ready : 1'b1);

    case (r_state)
      StIdle: begin
        if (w_adv) w_state_nxt = StFetch;
      end
      StFetch: begin
        bus.mem_req = 1'b1;
        if (w_adv) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          w_state_nxt  = StDecode;
        end
      end
      StDecode: begin
        if (w_adv) begin
          w_op_reg_nxt = bus.op_code;
          if (bus.op_code == OPCODE_W'(OP_HALT)) begin
            w_state_nxt = StHalt;
          end else if (w_op_illegal) begin
            w_retired   = 1'b1;
            w_state_nxt = StFetch;
          end else begin
            w_state_nxt = StExec;
          end
        end
      end
      StExec: begin
        bus.alu_op = w_alu_op;
        if (w_is_load || w_is_store) begin
          if (w_adv) w_state_nxt = StMem;
        end else if (r_op_reg == OPCODE_W'(OP_BEQ)) begin
          bus.pc_src = PC_SRC_BRANCH;
          if (w_adv) begin
            bus.pc_write = bus.zero;
            w_retired    = 1'b1;
            w_state_nxt  = StFetch;
          end
        end else if (r_op_reg == OPCODE_W'(OP_JMP)) begin
          bus.pc_src = PC_SRC_JUMP;
          if (w_adv) begin
            bus.pc_write = 1'b1;
            w_retired    = 1'b1;
            w_state_nxt  = StFetch;
          end
        end else begin
          if (w_adv) w_state_nxt = StWb;
        end
      end
      StMem: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = w_is_store;
        if (w_adv) begin
          if (w_is_store) begin
            w_retired   = 1'b1;
            w_state_nxt = StFetch;
          end else begin
            w_state_nxt = StWb;
          end
        end
      end
      StWb: begin
        bus.wb_sel = w_is_load;
        if (w_adv) begin
          bus.reg_write = 1'b1;
          w_retired     = 1'b1;
          w_state_nxt   = StFetch;
        end
      end
      StHalt: begin
        bus.halted = 1'b1;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  assign bus.ctrl_state = r_state;
  assign bus.retired    = w_retired;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] r_perf_cycles, r_perf_instrs;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_perf_cycles <= '0;
      r_perf_instrs <= '0;
    end else begin
      if (r_state != StIdle && r_state != StHalt) r_perf_cycles <= r_perf_cycles + CNT_W'(1);
      if (w_retired) r_perf_instrs <= r_perf_instrs + CNT_W'(1);
    end
  end

  assign bus.perf_cycles = r_perf_cycles;
  assign bus.perf_instrs = r_perf_instrs;
`else
  assign bus.perf_cycles = '0;
  assign bus.perf_instrs = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed bench for multicycle_controller.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_multicycle_controller;
  import ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef CTRL_PERF_CNT_EN
  localparam int unsigned ExpHaltCycles = 6;
  localparam int unsigned ExpHaltInstrs = 1;
`else
  localparam int unsigned ExpHaltCycles = 0;
  localparam int unsigned ExpHaltInstrs = 0;
`endif

  always #5 clk = ~clk;

  multicycle_controller_if #(.OPCODE_W(4), .ALUOP_W(3), .CNT_W(32)) bus ();

  multicycle_controller #(
    .OPCODE_W (4),
    .ALUOP_W  (3),
    .CNT_W    (32)
  ) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {state, mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, wb_sel, alu_op, retired, halted}
  function automatic logic [31:0] ctl_vec(input logic [2:0] st, input logic req, input logic we,
                                          input logic irw, input logic pcw, input logic [1:0] src,
                                          input logic rw, input logic wbs, input logic [2:0] alu,
                                          input logic ret, input logic hlt);
    return {16'd0, st, req, we, irw, pcw, src, rw, wbs, alu, ret, hlt};
  endfunction

  function automatic logic [31:0] obs_vec();
    return ctl_vec(bus.ctrl_state, bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write,
                   bus.pc_src, bus.reg_write, bus.wb_sel, bus.alu_op, bus.retired, bus.halted);
  endfunction

  task automatic cyc(input logic stall, input logic ready);
    @(negedge clk);
    bus.stall     = stall;
    bus.mem_ready = ready;
    #1;
  endtask

  // Common expected vectors.
  logic [31:0] v_idle, v_fetch, v_fetch_hold, v_dec, v_halt;

  initial begin
    v_idle       = ctl_vec(3'd0, 0, 0, 0, 0, 2'd0, 0, 0, 3'd0, 0, 0);
    v_fetch      = ctl_vec(3'd1, 1, 0, 1, 1, 2'd0, 0, 0, 3'd0, 0, 0);
    v_fetch_hold = ctl_vec(3'd1, 1, 0, 0, 0, 2'd0, 0, 0, 3'd0, 0, 0);
    v_dec        = ctl_vec(3'd2, 0, 0, 0, 0, 2'd0, 0, 0, 3'd0, 0, 0);
    v_halt       = ctl_vec(3'd6, 0, 0, 0, 0, 2'd0, 0, 0, 3'd0, 0, 1);

    rst_n         = 1'b0;
    bus.stall     = 1'b0;
    bus.mem_ready = 1'b1;
    bus.zero      = 1'b0;
    bus.op_code   = 4'b0010;

    cyc(0, 1);
    check_eq("reset_ctl", obs_vec(), v_idle);
    check_eq("reset_perf_cycles", bus.perf_cycles, 32'd0);
    check_eq("reset_perf_instrs", bus.perf_instrs, 32'd0);

    // ALU op 0010: IDLE, FETCH, DECODE, EXEC, WB (retire in cycle 5).
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("add_c1_idle", obs_vec(), v_idle);
    cyc(0, 1); check_eq("add_c2_fetch", obs_vec(), v_fetch);
    cyc(0, 1); check_eq("add_c3_decode", obs_vec(), v_dec);
    cyc(0, 1); check_eq("add_c4_exec", obs_vec(), ctl_vec(3, 0, 0, 0, 0, 0, 0, 0, 3'd2, 0, 0));
    cyc(0, 1); check_eq("add_c5_wb", obs_vec(), ctl_vec(5, 0, 0, 0, 0, 0, 1, 0, 3'd0, 1, 0));

    // LOAD with three not-ready cycles in MEM: 8 cycles total.
    bus.op_code = OP_LOAD;
    cyc(0, 1); check_eq("ld_fetch", obs_vec(), v_fetch);
    cyc(0, 1); check_eq("ld_decode", obs_vec(), v_dec);
    cyc(0, 1); check_eq("ld_exec", obs_vec(), ctl_vec(3, 0, 0, 0, 0, 0, 0, 0, 3'd1, 0, 0));
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0); check_eq("ld_mem_wait", obs_vec(), ctl_vec(4, 1, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0));
    end
    cyc(0, 1); check_eq("ld_mem_done", obs_vec(), ctl_vec(4, 1, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0));
    cyc(0, 1); check_eq("ld_wb", obs_vec(), ctl_vec(5, 0, 0, 0, 0, 0, 1, 1, 3'd0, 1, 0));

    // BEQ not taken, then taken.
    bus.op_code = OP_BEQ;
    bus.zero    = 1'b0;
    cyc(0, 1); check_eq("beq0_fetch", obs_vec(), v_fetch);
    cyc(0, 1); check_eq("beq0_decode", obs_vec(), v_dec);
    cyc(0, 1); check_eq("beq0_exec", obs_vec(), ctl_vec(3, 0, 0, 0, 0, 2'd1, 0, 0, 3'd1, 1, 0));
    bus.zero = 1'b1;
    cyc(0, 1); check_eq("beq1_fetch", obs_vec(), v_fetch);
    cyc(0, 1); check_eq("beq1_decode", obs_vec(), v_dec);
    cyc(0, 1); check_eq("beq1_exec", obs_vec(), ctl_vec(3, 0, 0, 0, 1, 2'd1, 0, 0, 3'd1, 1, 0));
    bus.zero = 1'b0;

    // JMP.
    bus.op_code = OP_JMP;
    cyc(0, 1); check_eq("jmp_fetch", obs_vec(), v_fetch);
    cyc(0, 1); check_eq("jmp_decode", obs_vec(), v_dec);
    cyc(0, 1); check_eq("jmp_exec", obs_vec(), ctl_vec(3, 0, 0, 0, 1, 2'd2, 0, 0, 3'd1, 1, 0));

    // Opcode 0101 stalled two cycles in EXEC.
    bus.op_code = OP_OR;
    cyc(0, 1); check_eq("or_fetch", obs_vec(), v_fetch);
    cyc(0, 1); check_eq("or_decode", obs_vec(), v_dec);
    cyc(1, 1); check_eq("or_exec_stall1", obs_vec(), ctl_vec(3, 0, 0, 0, 0, 0, 0, 0, 3'd3, 0, 0));
    cyc(1, 1); check_eq("or_exec_stall2", obs_vec(), ctl_vec(3, 0, 0, 0, 0, 0, 0, 0, 3'd3, 0, 0));
    cyc(0, 1); check_eq("or_exec_go", obs_vec(), ctl_vec(3, 0, 0, 0, 0, 0, 0, 0, 3'd3, 0, 0));
    cyc(0, 1); check_eq("or_wb", obs_vec(), ctl_vec(5, 0, 0, 0, 0, 0, 1, 0, 3'd0, 1, 0));

    // STORE with FETCH held by stall (ready high, not consumed) then by not-ready.
    bus.op_code = OP_STORE;
    cyc(1, 1); check_eq("st_fetch_stall", obs_vec(), v_fetch_hold);
    cyc(0, 0); check_eq("st_fetch_notrdy", obs_vec(), v_fetch_hold);
    cyc(0, 1); check_eq("st_fetch", obs_vec(), v_fetch);
    cyc(0, 1); check_eq("st_decode", obs_vec(), v_dec);
    cyc(0, 1); check_eq("st_exec", obs_vec(), ctl_vec(3, 0, 0, 0, 0, 0, 0, 0, 3'd1, 0, 0));
    cyc(0, 1); check_eq("st_mem", obs_vec(), ctl_vec(4, 1, 1, 0, 0, 0, 0, 0, 3'd0, 1, 0));

    // STORE interrupted by asynchronous reset in MEM.
    cyc(0, 1); check_eq("st2_fetch", obs_vec(), v_fetch);
    cyc(0, 1); check_eq("st2_decode", obs_vec(), v_dec);
    cyc(0, 1); check_eq("st2_exec", obs_vec(), ctl_vec(3, 0, 0, 0, 0, 0, 0, 0, 3'd1, 0, 0));
    cyc(0, 0); check_eq("st2_mem", obs_vec(), ctl_vec(4, 1, 1, 0, 0, 0, 0, 0, 3'd0, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_ctl", obs_vec(), v_idle);
    cyc(0, 1); check_eq("rst_hold_ctl", obs_vec(), v_idle);
    bus.op_code = OP_SUB;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rel_idle", obs_vec(), v_idle);
    cyc(0, 1); check_eq("sub_fetch", obs_vec(), v_fetch);
    cyc(0, 1); check_eq("sub_decode", obs_vec(), v_dec);
    cyc(0, 1); check_eq("sub_exec", obs_vec(), ctl_vec(3, 0, 0, 0, 0, 0, 0, 0, 3'd6, 0, 0));
    cyc(0, 1); check_eq("sub_wb", obs_vec(), ctl_vec(5, 0, 0, 0, 0, 0, 1, 0, 3'd0, 1, 0));

    // HALT is absorbing and ignores stall / handshake activity.
    bus.op_code = OP_HALT;
    cyc(0, 1); check_eq("halt_fetch", obs_vec(), v_fetch);
    cyc(0, 1); check_eq("halt_decode", obs_vec(), v_dec);
    cyc(0, 1); check_eq("halt_enter", obs_vec(), v_halt);
    bus.op_code = OP_ADD;
    cyc(1, 0); check_eq("halt_stall", obs_vec(), v_halt);
    cyc(0, 1); check_eq("halt_hold1", obs_vec(), v_halt);
    check_eq("halt_perf_cycles_a", bus.perf_cycles, ExpHaltCycles);
    check_eq("halt_perf_instrs_a", bus.perf_instrs, ExpHaltInstrs);
    for (int i = 0; i < 4; i++) cyc(0, 1);
    check_eq("halt_hold2", obs_vec(), v_halt);
    check_eq("halt_perf_cycles_b", bus.perf_cycles, ExpHaltCycles);
    check_eq("halt_perf_instrs_b", bus.perf_instrs, ExpHaltInstrs);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
